// File: rtl/i2s_frame_sequencer.sv
// ============================================================================
//  Module   : i2s_frame_sequencer
//  Purpose  : Drives a PCM5102-class I2S DAC (SCK tied low) from the system
//             clock. A fractional phase accumulator produces BCK. One stereo
//             frame is shifted per LRCK period in Philips I2S format. Samples
//             enter through a one-deep valid/ready holding register.
//  Ports    : clk, sys_rst_i (sync, active-high)
//             enable                      run request, sampled at frame ends
//             sample_left/right/valid     upstream stereo pair offer
//             sample_ready                holding register empty
//             i2s_bck/i2s_lrck/i2s_din    DAC pins (all registered)
//             underrun                    1-clk pulse: frame loaded while empty
//             running                     high in PRIME and RUN
//  Options  : `define I2S_UNDERRUN_REPEAT_EN to replay the last good frame on
//             underrun. When undefined, underrun transmits silence.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_frame_sequencer #(
  parameter int CLK_HZ = 12000000,
  parameter int BCK_HZ = 1411200,
  parameter int WORD_W = 16,
  parameter int ACC_W  = 25
) (
  input  logic              clk,
  input  logic              sys_rst_i,
  input  logic              enable,
  input  logic [WORD_W-1:0] sample_left,
  input  logic [WORD_W-1:0] sample_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              i2s_bck,
  output logic              i2s_lrck,
  output logic              i2s_din,
  output logic              underrun,
  output logic              running
);

  localparam int                FRAME_W   = 2 * WORD_W;
  localparam int                SLOT_W    = $clog2(FRAME_W);
  localparam logic [ACC_W-1:0]  INC       = ACC_W'(2 * BCK_HZ);
  localparam logic [ACC_W-1:0]  MODULUS   = ACC_W'(CLK_HZ);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_W - 1);
  localparam logic [SLOT_W-1:0] LRCK_RISE = SLOT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [FRAME_W-1:0]  hold_q, hold_d;
  logic                full_q, full_d;
  logic                bck_q, bck_d;
  logic                lrck_q, lrck_d;
  logic                din_q, din_d;
  logic                und_q, und_d;
  logic                run_q;
  logic                ready_q;

  logic [ACC_W-1:0]    w_sum;
  logic                w_tick;
  logic                w_fall;
  logic                w_xfer;
  logic                w_load;
  logic                w_emit;
  logic [FRAME_W-1:0]  w_fill;

`ifdef I2S_UNDERRUN_REPEAT_EN
  logic [FRAME_W-1:0]  last_q, last_d;

  // Remember every frame that came from the holding register.
  always_comb begin
    last_d = last_q;
    if (w_load && full_q) last_d = hold_q;
  end

  always_ff @(posedge clk) begin
    if (sys_rst_i) last_q <= '0;
    else           last_q <= last_d;
  end

  assign w_fill = last_q;
`else
  assign w_fill = '0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    full_d  = full_q;
    bck_d   = bck_q;
    lrck_d  = lrck_q;
    din_d   = din_q;
    und_d   = 1'b0;
    w_load  = 1'b0;
    w_emit  = 1'b0;

    // acc < CLK_HZ always, and the width leaves room for +INC, so no wrap.
    w_sum  = acc_q + INC;
    w_tick = (w_sum >= MODULUS);
    w_fall = w_tick & bck_q;
    w_xfer = sample_valid & ~full_q;

    case (state_q)
      ST_IDLE: begin
        acc_d  = '0;
        bck_d  = 1'b0;
        lrck_d = 1'b0;
        din_d  = 1'b0;
        slot_d = '0;
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME, ST_RUN: begin
        acc_d = w_tick ? (w_sum - MODULUS) : w_sum;
        if (w_tick) bck_d = ~bck_q;
        if (w_fall) begin
          if (state_q == ST_PRIME) begin
            state_d = ST_RUN;
            w_load  = 1'b1;
            w_emit  = 1'b1;
            slot_d  = '0;
          end else if (slot_q == LAST_SLOT) begin
            if (enable) begin
              w_load = 1'b1;
              w_emit = 1'b1;
              slot_d = '0;
            end else begin
              state_d = ST_IDLE;
              acc_d   = '0;
              lrck_d  = 1'b0;
              din_d   = 1'b0;
              slot_d  = '0;
            end
          end else begin
            w_emit = 1'b1;
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A load consumes the old holding contents; a same-cycle transfer below
    // refills the register for the following frame.
    if (w_load) begin
      if (full_q) begin
        frame_d = hold_q;
        full_d  = 1'b0;
      end else begin
        frame_d = w_fill;
        und_d   = 1'b1;
      end
    end

    // Frame bit index counts down from the MSB of {L,R}; LRCK goes high one
    // slot before the right word and drops one slot before the left word.
    if (w_emit) begin
      din_d  = frame_d[LAST_SLOT - slot_d];
      lrck_d = (slot_d >= LRCK_RISE) && (slot_d != LAST_SLOT);
    end

    if (w_xfer) begin
      hold_d = {sample_left, sample_right};
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      din_q   <= 1'b0;
      und_q   <= 1'b0;
      run_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      bck_q   <= bck_d;
      lrck_q  <= lrck_d;
      din_q   <= din_d;
      und_q   <= und_d;
      run_q   <= (state_d != ST_IDLE);
      ready_q <= ~full_d;
    end
  end

  assign sample_ready = ready_q;
  assign i2s_bck      = bck_q;
  assign i2s_lrck     = lrck_q;
  assign i2s_din      = din_q;
  assign underrun     = und_q;
  assign running      = run_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_sequencer.sv
// ============================================================================
//  Module   : tb_i2s_frame_sequencer
//  Purpose  : Self-checking bench. Instance A (BCK 1.5 MHz) is compared every
//             cycle against a frame-level reference model. Instance B
//             (BCK 1.4112 MHz) has its BCK phase lengths and LRCK rate measured.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_frame_sequencer;

  localparam int     CLK_HZ = 12000000;
  localparam int     BCK_A  = 1500000;
  localparam int     BCK_B  = 1411200;
  localparam longint INC_A  = 2 * BCK_A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        rst, en, valid;
  logic [15:0] sl, sr;
  logic        ready, bck, lrck, din, und, run;

  i2s_frame_sequencer #(.CLK_HZ(CLK_HZ), .BCK_HZ(BCK_A), .WORD_W(16), .ACC_W(25)) u_dut_a (
    .clk(clk), .sys_rst_i(rst), .enable(en),
    .sample_left(sl), .sample_right(sr), .sample_valid(valid), .sample_ready(ready),
    .i2s_bck(bck), .i2s_lrck(lrck), .i2s_din(din), .underrun(und), .running(run)
  );

  // Instance B
  logic rst_b, en_b;
  logic ready_b, bck_b, lrck_b, din_b, und_b, run_b;
  logic done_b;

  i2s_frame_sequencer #(.CLK_HZ(CLK_HZ), .BCK_HZ(BCK_B), .WORD_W(16), .ACC_W(25)) u_dut_b (
    .clk(clk), .sys_rst_i(rst_b), .enable(en_b),
    .sample_left(16'h0000), .sample_right(16'h0000), .sample_valid(1'b0), .sample_ready(ready_b),
    .i2s_bck(bck_b), .i2s_lrck(lrck_b), .i2s_din(din_b), .underrun(und_b), .running(run_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: time t counts clks since PRIME entry; ticks so far are
  // floor(t*2*BCK/CLK); every second tick is a falling edge; falling edge f
  // begins slot (f-1) mod 32 and every 32nd one starts a new frame.
  bit          m_active, m_full, m_bck, m_din, m_lrck, m_und;
  longint      m_t;
  int          m_slot;
  logic [31:0] m_hold, m_frame, m_last;

  // Bench-side capture of DUT A serial output on its BCK falling edges
  logic [31:0] cap_din, cap_lrck;
  int          n_fall;
  logic        prev_bck;

  task automatic model_reset();
    m_active = 0; m_full = 0; m_bck = 0; m_din = 0; m_lrck = 0; m_und = 0;
    m_t = 0; m_slot = 0; m_hold = '0; m_frame = '0; m_last = '0;
  endtask

  task automatic model_load();
    if (m_full) begin
      m_frame = m_hold;
      m_last  = m_hold;
      m_full  = 0;
    end else begin
      m_und = 1;
`ifdef I2S_UNDERRUN_REPEAT_EN
      m_frame = m_last;
`else
      m_frame = '0;
`endif
    end
  endtask

  function automatic bit next_edge_loads();
    longint k, kp, f;
    if (rst || !m_active) return 0;
    k  = (m_t + 1) * INC_A / CLK_HZ;
    kp = m_t * INC_A / CLK_HZ;
    if (k == kp || (k % 2) != 0) return 0;
    f = k / 2;
    return ((f - 1) % 32 == 0) && (f == 1 || en);
  endfunction

  // Advance one clk (inputs sampled at the posedge), update the model, and
  // compare every DUT A output on the following negedge.
  task automatic step();
    bit     xfer;
    longint k, kp, f;
    @(negedge clk);
    m_und = 0;
    if (rst) begin
      model_reset();
    end else begin
      xfer = valid && !m_full;
      if (!m_active) begin
        if (en) begin
          m_active = 1;
          m_t      = 0;
        end
      end else begin
        m_t++;
        k     = m_t * INC_A / CLK_HZ;
        kp    = (m_t - 1) * INC_A / CLK_HZ;
        m_bck = ((k % 2) == 1);
        if (k != kp && (k % 2) == 0) begin
          f = k / 2;
          if (f > 1 && ((f - 1) % 32) == 0 && !en) begin
            m_active = 0; m_din = 0; m_lrck = 0; m_bck = 0;
          end else begin
            if (((f - 1) % 32) == 0) model_load();
            m_slot = int'((f - 1) % 32);
            m_din  = m_frame[31 - m_slot];
            m_lrck = (m_slot >= 15) && (m_slot <= 30);
          end
        end
      end
      if (xfer) begin
        m_hold = {sl, sr};
        m_full = 1;
      end
    end
    check("bck", bck, m_bck);
    check("lrck", lrck, m_lrck);
    check("din", din, m_din);
    check("underrun", und, m_und);
    check("running", run, m_active);
    check("ready", ready, !m_full);
    if (prev_bck === 1'b1 && bck === 1'b0) begin
      cap_din  = {cap_din[30:0], din};
      cap_lrck = {cap_lrck[30:0], lrck};
      n_fall++;
    end
    prev_bck = bck;
  endtask

  task automatic run_until_falls(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_fall >= target) break;
      step();
    end
    check("fall_count_reached", n_fall >= target, 1);
  endtask

  // Instance B: BCK phase lengths and the length of ten LRCK periods
  initial begin : mon_b
    int   cb, last_tog, n_tog, rises, first_rise;
    logic pb, pl;
    done_b = 0;
    cb = 0; last_tog = 0; n_tog = 0; rises = 0; first_rise = 0;
    pb = 0; pl = 0;
    @(negedge clk);
    while (rst_b !== 1'b0) @(negedge clk);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      cb++;
      check("b_din_silent", din_b, 0);
      if (bck_b !== pb) begin
        if (n_tog > 0) check("b_bck_phase_4_or_5", ((cb - last_tog) == 4) || ((cb - last_tog) == 5), 1);
        last_tog = cb;
        n_tog++;
      end
      if (lrck_b === 1'b1 && pl === 1'b0) begin
        if (rises == 0) first_rise = cb;
        rises++;
        if (rises == 11) begin
          check("b_lrck_10_periods", ((cb - first_rise) >= 2720) && ((cb - first_rise) <= 2722), 1);
          break;
        end
      end
      pb = bck_b;
      pl = lrck_b;
    end
    done_b = 1;
  end

  initial begin : main
    logic [31:0] pair;
    int          lat, cnt, und_seen;
    bit          found;

    rst = 1; en = 0; valid = 0; sl = '0; sr = '0;
    rst_b = 1; en_b = 0;
    model_reset();
    cap_din = '0; cap_lrck = '0; n_fall = 0; prev_bck = 0;
    repeat (3) step();
    rst = 0; rst_b = 0; en_b = 1;

    // Idle with enable low
    repeat (100) step();
    check("idle_ready", ready, 1);
    check("idle_running", run, 0);
    check("idle_pins", {bck, lrck, din}, 3'b000);

    // Known pair, then enable
    sl = 16'hA5C3; sr = 16'h0F01; valid = 1;
    step();
    valid = 0;
    en = 1; n_fall = 0;
    step();
    check("prime_running", run, 1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (n_fall >= 1) begin lat = i; break; end
    end
    check("first_fall_latency", lat, 8);
    run_until_falls(32, 400);
    check("frame1_din", cap_din, 32'hA5C30F01);
    check("frame1_lrck", cap_lrck, 32'h0001FFFE);

    // 8001/8001 frame, then starve the input
    sl = 16'h8001; sr = 16'h8001; valid = 1;
    step();
    valid = 0;
    und_seen = 0;
    for (int i = 0; i < 600 && n_fall < 64; i++) begin
      step();
      if (und === 1'b1) und_seen++;
    end
    check("frame2_din", cap_din, 32'h80018001);
    for (int i = 0; i < 600 && n_fall < 96; i++) begin
      step();
      if (und === 1'b1) und_seen++;
    end
`ifdef I2S_UNDERRUN_REPEAT_EN
    check("frame3_repeat_din", cap_din, 32'h80018001);
`else
    check("frame3_mute_din", cap_din, 32'h00000000);
`endif
    check("starve_underrun_count", und_seen, 1);

    // Offer a pair on the exact clk of a load with the register empty
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (next_edge_loads() && !m_full) begin found = 1; break; end
      step();
    end
    check("found_load_edge", found, 1);
    pair = $urandom;
    sl = pair[31:16]; sr = pair[15:0]; valid = 1; n_fall = 0;
    step();
    valid = 0;
    check("coload_underrun", und, 1);
    check("coload_ready", ready, 0);
    run_until_falls(64, 700);
    check("coload_next_frame_din", cap_din, pair);

    // Drop enable at slot 5: the frame completes, then IDLE
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_active && m_slot == 5 && prev_bck === 1'b0 && n_fall > 0) begin found = 1; break; end
      step();
    end
    check("found_slot5", found, 1);
    en = 0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (run === 1'b0) break;
      step();
      cnt++;
    end
    check("stop_cycles_after_slot5", cnt, 216);
    check("stopped_pins", {bck, lrck, din, run}, 4'b0000);
    repeat (20) step();

    // Restart, reset at slot 10 of the second frame
    en = 1; n_fall = 0;
    run_until_falls(43, 800);
    rst = 1;
    step();
    check("midframe_reset_pins", {bck, lrck, din, und, run}, 5'b00000);
    check("midframe_reset_ready", ready, 1);
    rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      valid = ($urandom_range(0, 199) == 0) || (valid && !ready);
      if (!valid || ready) begin
        sl = 16'($urandom);
        sr = 16'($urandom);
      end
      if ($urandom_range(0, 1499) == 0) en = ~en;
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    rst = 0; valid = 0;

    for (int i = 0; i < 6000 && !done_b; i++) step();
    check("b_monitor_done", done_b, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
